// File: rtl/coin_acceptor_if.sv
// Sensor-side and vending-side signals of the coin acceptor, bundled for port use.
// The acceptor takes the slave view; whatever drives the sensors takes the master view.
interface coin_acceptor_if;
  logic       raw_5;
  logic       raw_10;
  logic       raw_20;
  logic       accept_en;
  logic       clear_total;
  logic [1:0] coin;
  logic       reject;
  logic       err_multi;
  logic [2:0] fifo_count;
  logic [7:0] total_rs;

  modport master (
    output raw_5, raw_10, raw_20, accept_en, clear_total,
    input  coin, reject, err_multi, fifo_count, total_rs
  );

  modport slave (
    input  raw_5, raw_10, raw_20, accept_en, clear_total,
    output coin, reject, err_multi, fifo_count, total_rs
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronise and debounce three coin sensors, queue accepted
// coins in a 4-deep FIFO and pace them out as single-cycle codes with a fixed idle gap.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 2
) (
  input logic           clk,
  input logic           rst,
  coin_acceptor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  logic [2:0] raw;
  logic [2:0] sync1, sync2;
  logic [2:0] settled, settled_d;
  logic [2:0] event_q;
  logic [7:0] deb_cnt [3];

  logic [1:0] fifo_mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;

  state_t     state;
  logic [3:0] gap_cnt;
  logic [1:0] coin_q;
  logic       reject_q, err_q;
  logic [7:0] total_q;

  logic       ready, pop, push, any_ev, multi;
  logic [1:0] push_code;
  logic [7:0] coin_value;
  logic [8:0] sum;

  assign raw = {bus.raw_20, bus.raw_10, bus.raw_5};

  // Channel bit 0 = Rs.5, bit 1 = Rs.10, bit 2 = Rs.20.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 3'b000;
      sync2     <= 3'b000;
      settled   <= 3'b000;
      settled_d <= 3'b000;
      event_q   <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= 8'd0;
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      settled_d <= settled;
      event_q   <= settled & ~settled_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == settled[i]) begin
          deb_cnt[i] <= 8'd0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          settled[i] <= sync2[i];
          deb_cnt[i] <= 8'd0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  // The output side may pop again in the last zero cycle of the gap (or in EMIT when
  // there is no gap), so back-to-back codes are separated by exactly GAP_CYCLES zeros.
  assign ready = (state == IDLE)
              || (state == EMIT && GAP_CYCLES == 0)
              || (state == GAP && gap_cnt == GAP_LAST);
  assign pop   = ready && (count != 3'd0) && bus.accept_en;

  assign any_ev    = |event_q;
  assign multi     = (event_q[0] & event_q[1]) | (event_q[0] & event_q[2]) | (event_q[1] & event_q[2]);
  assign push      = any_ev && !multi && bus.accept_en && ((count != 3'd4) || pop);
  assign push_code = event_q[2] ? 2'b11 : (event_q[1] ? 2'b10 : 2'b01);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      count    <= 3'd0;
      reject_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      reject_q <= any_ev && !push;
      err_q    <= multi;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  always_comb begin
    coin_value = 8'd0;
    case (coin_q)
      2'b01:   coin_value = 8'd5;
      2'b10:   coin_value = 8'd10;
      2'b11:   coin_value = 8'd20;
      default: coin_value = 8'd0;
    endcase
  end

  assign sum = {1'b0, total_q} + {1'b0, coin_value};

  // coin_q holds the popped code for the single EMIT cycle; the total follows one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= 4'd0;
      coin_q  <= 2'b00;
      total_q <= 8'd0;
    end else begin
      coin_q <= 2'b00;
      if (bus.clear_total)
        total_q <= (state == EMIT) ? coin_value : 8'd0;
      else if (state == EMIT)
        total_q <= sum[8] ? 8'd255 : sum[7:0];

      if (pop) begin
        state   <= EMIT;
        coin_q  <= fifo_mem[rd_ptr];
        gap_cnt <= 4'd0;
      end else begin
        case (state)
          EMIT: begin
            state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
            gap_cnt <= 4'd0;
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) state <= IDLE;
            else gap_cnt <= gap_cnt + 4'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.coin       = coin_q;
  assign bus.reject     = reject_q;
  assign bus.err_multi  = err_q;
  assign bus.fifo_count = count;
  assign bus.total_rs   = total_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random sensor traffic, every cycle
// compared against an abstract model built on sensor history windows and a coin queue.
module tb_coin_acceptor;

  localparam int DEB = 3;
  localparam int GAP = 15;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  coin_acceptor_if bus();

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state, describing the outputs expected after the most recent rising edge.
  logic [2:0]  m_s1, m_s2, m_settled, m_rise1, m_evt;
  logic [63:0] m_hist [3];
  int          m_q[$];
  int          m_age;
  int          m_coin;
  int          m_total;
  bit          m_reject, m_err;

  function automatic int codeValue(input int c);
    case (c)
      1:       return 5;
      2:       return 10;
      3:       return 20;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // A settled level flips once the last DEB synchronised samples all disagree with it;
  // an accepted coin may leave the queue once GAP cycles have passed since the last code.
  task automatic modelStep(input logic [2:0] r, input logic ae, input logic clr, input logic rs);
    int          n_ev;
    bit          pop;
    bit          full_pre;
    int          pcode;
    int          cur_val;
    int          ch;
    logic [2:0]  rise;
    logic [63:0] mask;
    mask = (64'd1 << DEB) - 64'd1;
    if (rs) begin
      m_s1 = 3'b000; m_s2 = 3'b000; m_settled = 3'b000; m_rise1 = 3'b000; m_evt = 3'b000;
      for (int c = 0; c < 3; c++) m_hist[c] = 64'd0;
      m_q.delete();
      m_age = 100; m_coin = 0; m_total = 0; m_reject = 0; m_err = 0;
      return;
    end
    n_ev     = $countones(m_evt);
    pop      = (m_age >= GAP) && (m_q.size() > 0) && ae;
    full_pre = (m_q.size() == 4);
    cur_val  = codeValue(m_coin);
    if (clr) m_total = cur_val;
    else if (cur_val != 0) m_total = (m_total + cur_val > 255) ? 255 : m_total + cur_val;
    pcode = 0;
    if (pop) pcode = m_q.pop_front();
    m_reject = 0;
    m_err    = 0;
    if (n_ev >= 2) begin
      m_reject = 1;
      m_err    = 1;
    end else if (n_ev == 1) begin
      ch = m_evt[2] ? 3 : (m_evt[1] ? 2 : 1);
      if (!ae || (full_pre && !pop)) m_reject = 1;
      else m_q.push_back(ch);
    end
    m_coin = pcode;
    m_age  = pop ? 0 : ((m_age < 100) ? m_age + 1 : 100);
    rise   = 3'b000;
    for (int c = 0; c < 3; c++) begin
      m_hist[c] = {m_hist[c][62:0], m_s2[c]};
      if (!m_settled[c] && ((m_hist[c] & mask) == mask)) begin
        m_settled[c] = 1'b1;
        rise[c]      = 1'b1;
      end else if (m_settled[c] && ((m_hist[c] & mask) == 64'd0)) begin
        m_settled[c] = 1'b0;
      end
    end
    m_evt   = m_rise1;
    m_rise1 = rise;
    m_s2    = m_s1;
    m_s1    = r;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic ae, input logic clr, input logic rs);
    bus.raw_5       = r[0];
    bus.raw_10      = r[1];
    bus.raw_20      = r[2];
    bus.accept_en   = ae;
    bus.clear_total = clr;
    rst             = rs;
    modelStep(r, ae, clr, rs);
    @(negedge clk);
    checkOutput("coin",       int'(bus.coin),       m_coin);
    checkOutput("reject",     int'(bus.reject),     int'(m_reject));
    checkOutput("err_multi",  int'(bus.err_multi),  int'(m_err));
    checkOutput("fifo_count", int'(bus.fifo_count), m_q.size());
    checkOutput("total_rs",   int'(bus.total_rs),   m_total);
  endtask

  // Holds r for hi cycles then releases for lo cycles, gathering output statistics.
  task automatic runPulse(input logic [2:0] r, input int hi, input int lo, input logic ae,
                          output int n_coin, output int n_rej, output int n_err,
                          output int first_at, output int last_at, output int peak);
    n_coin = 0; n_rej = 0; n_err = 0; first_at = -1; last_at = -1; peak = 0;
    for (int i = 1; i <= hi + lo; i++) begin
      applyStimulus((i <= hi) ? r : 3'b000, ae, 1'b0, 1'b0);
      if (bus.coin != 2'b00) begin
        n_coin++;
        if (first_at < 0) first_at = i;
        last_at = i;
      end
      if (bus.reject) n_rej++;
      if (bus.err_multi) n_err++;
      if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    end
  endtask

  initial begin
    int         nc, nr, ne, fa, la, pk;
    int         acc_c, acc_r, acc_e, acc_p;
    int         hi, lo;
    logic [2:0] msk;
    logic       ae;

    bus.raw_5 = 1'b0; bus.raw_10 = 1'b0; bus.raw_20 = 1'b0;
    bus.accept_en = 1'b0; bus.clear_total = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_coin",  int'(bus.coin), 0);
    checkOutput("rst_rej",   int'(bus.reject), 0);
    checkOutput("rst_err",   int'(bus.err_multi), 0);
    checkOutput("rst_count", int'(bus.fifo_count), 0);
    checkOutput("rst_total", int'(bus.total_rs), 0);

    $display("[TB] single coin");
    runPulse(3'b010, 30, 20, 1'b1, nc, nr, ne, fa, la, pk);
    checkOutput("single_n",     nc, 1);
    checkOutput("single_lat",   fa, DEB + 5);
    checkOutput("single_rej",   nr, 0);
    checkOutput("single_total", int'(bus.total_rs), 10);

    $display("[TB] glitch");
    runPulse(3'b001, DEB - 1, 2 * DEB + 4, 1'b1, nc, nr, ne, fa, la, pk);
    checkOutput("glitch_n",    nc, 0);
    checkOutput("glitch_peak", pk, 0);

    $display("[TB] overflow");
    acc_c = 0; acc_r = 0; acc_e = 0; acc_p = 0;
    repeat (12) begin
      runPulse(3'b001, DEB + 1, DEB, 1'b1, nc, nr, ne, fa, la, pk);
      acc_c += nc; acc_r += nr; acc_e += ne;
      if (pk > acc_p) acc_p = pk;
    end
    runPulse(3'b000, 0, 100, 1'b1, nc, nr, ne, fa, la, pk);
    acc_c += nc; acc_r += nr;
    checkOutput("ovf_peak",    acc_p, 4);
    checkOutput("ovf_rej_any", int'(acc_r > 0), 1);
    checkOutput("ovf_balance", acc_c + acc_r, 12);
    checkOutput("ovf_err",     acc_e, 0);

    $display("[TB] simultaneous sensors");
    runPulse(3'b101, 30, 20, 1'b1, nc, nr, ne, fa, la, pk);
    checkOutput("multi_n",   nc, 0);
    checkOutput("multi_rej", nr, 1);
    checkOutput("multi_err", ne, 1);

    $display("[TB] disabled insertion");
    runPulse(3'b010, 10, 10, 1'b0, nc, nr, ne, fa, la, pk);
    checkOutput("dis_rej", nr, 1);
    checkOutput("dis_n",   nc, 0);

    $display("[TB] held coins");
    runPulse(3'b000, 0, 40, 1'b1, nc, nr, ne, fa, la, pk);
    acc_c = 0;
    repeat (3) begin
      runPulse(3'b001, DEB + 1, DEB, 1'b1, nc, nr, ne, fa, la, pk);
      acc_c += nc;
    end
    checkOutput("held_first",  acc_c, 1);
    checkOutput("held_queued", int'(bus.fifo_count), 2);
    runPulse(3'b000, 0, 50, 1'b0, nc, nr, ne, fa, la, pk);
    checkOutput("held_off_n", nc, 0);
    runPulse(3'b000, 0, 40, 1'b1, nc, nr, ne, fa, la, pk);
    checkOutput("held_on_n",   nc, 2);
    checkOutput("held_gap",    la - fa, GAP + 1);

    $display("[TB] reset with queued coins");
    repeat (5) runPulse(3'b001, DEB + 1, DEB, 1'b1, nc, nr, ne, fa, la, pk);
    checkOutput("rq_queued", int'(bus.fifo_count), 3);
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b1);
    checkOutput("rq_count", int'(bus.fifo_count), 0);
    checkOutput("rq_coin",  int'(bus.coin), 0);
    runPulse(3'b000, 0, 40, 1'b1, nc, nr, ne, fa, la, pk);
    checkOutput("rq_after_n",   nc, 0);
    checkOutput("rq_after_rej", nr, 0);

    $display("[TB] saturation");
    applyStimulus(3'b000, 1'b1, 1'b1, 1'b0);
    checkOutput("sat_clear", int'(bus.total_rs), 0);
    acc_c = 0; acc_r = 0;
    repeat (13) begin
      runPulse(3'b100, DEB + 1, 12, 1'b1, nc, nr, ne, fa, la, pk);
      acc_c += nc; acc_r += nr;
    end
    runPulse(3'b000, 0, 40, 1'b1, nc, nr, ne, fa, la, pk);
    acc_c += nc;
    checkOutput("sat_n",     acc_c, 13);
    checkOutput("sat_rej",   acc_r, 0);
    checkOutput("sat_total", int'(bus.total_rs), 255);

    $display("[TB] clear coincident with emit");
    for (int i = 1; i <= DEB + 12; i++) begin
      applyStimulus((i <= DEB + 1) ? 3'b001 : 3'b000, 1'b1, (i == DEB + 6), 1'b0);
      if (i == DEB + 5) checkOutput("clr_coin",  int'(bus.coin), 1);
      if (i == DEB + 6) checkOutput("clr_total", int'(bus.total_rs), 5);
    end
    checkOutput("clr_total_hold", int'(bus.total_rs), 5);

    $display("[TB] random traffic");
    repeat (400) begin
      case ($urandom_range(0, 7))
        0, 1:    msk = 3'b001;
        2:       msk = 3'b010;
        3, 4:    msk = 3'b100;
        5:       msk = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b110;
        6:       msk = 3'b000;
        default: msk = 3'b101;
      endcase
      hi = $urandom_range(1, DEB + 4);
      lo = $urandom_range(1, DEB + 8);
      ae = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < hi + lo; i++)
        applyStimulus((i < hi) ? msk : 3'b000, ae, ($urandom_range(0, 29) == 0),
                      ($urandom_range(0, 299) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
